// File: rtl/s713_resp_misr_if.sv
// rtl/s713_resp_misr_if.sv - response/status bundle between the s713 core, the MISR and the readout logic
//
// Purpose : groups the run-control, response and status signals of s713_resp_misr.
// Signals : START      run request pulse              (master -> slave)
//           VALID      RESP carries a real response   (master -> slave)
//           RESP       s713 primary outputs, MSB first (master -> slave)
//           BUSY       compactor in SKIP or RUN       (slave -> master)
//           DONE       final signature held           (slave -> master)
//           PAT_CNT    patterns compacted this run    (slave -> master)
//           SIGNATURE  current MISR contents          (slave -> master)
// Macro   : S713_RESP_MISR_CMP_EN adds EXP_SIG (master -> slave) and PASS (slave -> master).

interface s713_resp_misr_if #(
    parameter int WIDTH = 23
);
    logic             START;
    logic             VALID;
    logic [WIDTH-1:0] RESP;
    logic             BUSY;
    logic             DONE;
    logic [15:0]      PAT_CNT;
    logic [WIDTH-1:0] SIGNATURE;
`ifdef S713_RESP_MISR_CMP_EN
    logic [WIDTH-1:0] EXP_SIG;
    logic             PASS;

    modport master (
        output START, VALID, RESP, EXP_SIG,
        input  BUSY, DONE, PAT_CNT, SIGNATURE, PASS
    );

    modport slave (
        input  START, VALID, RESP, EXP_SIG,
        output BUSY, DONE, PAT_CNT, SIGNATURE, PASS
    );
`else
    modport master (
        output START, VALID, RESP,
        input  BUSY, DONE, PAT_CNT, SIGNATURE
    );

    modport slave (
        input  START, VALID, RESP,
        output BUSY, DONE, PAT_CNT, SIGNATURE
    );
`endif
endinterface

// File: rtl/s713_resp_misr.sv
// rtl/s713_resp_misr.sv - multiple-input signature register compacting s713 responses
//
// Purpose : skips WARMUP valid responses after START while the s713 flip-flops
//           settle, folds the next NUM_PATTERNS valid responses into a MISR and
//           then freezes the signature for readout until the next START.
// Ports   : CK    clock, rising edge
//           RST   asynchronous active-high reset
//           bus   s713_resp_misr_if.slave
//                   in : START, VALID, RESP[WIDTH-1:0]
//                   out: BUSY, DONE, PAT_CNT[15:0], SIGNATURE[WIDTH-1:0]
// Macro   : S713_RESP_MISR_CMP_EN adds bus.EXP_SIG (in) and bus.PASS (out), a
//           registered signature-match flag that is valid one cycle after DONE.
//           Undefined: no comparator is built.

module s713_resp_misr #(
    parameter int               WIDTH        = 23,
    parameter logic [WIDTH-1:0] POLY         = 23'h000021,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter int               WARMUP       = 4,
    parameter int               NUM_PATTERNS = 1024
) (
    input  logic              CK,
    input  logic              RST,
    s713_resp_misr_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0]  WU = 8'(WARMUP);
    localparam logic [15:0] NP = 16'(NUM_PATTERNS);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sig;
    logic [15:0]      r_pat;
    logic [7:0]       r_skip;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [15:0]      w_pat_nxt;
    logic [7:0]       w_skip_nxt;
    logic [WIDTH-1:0] w_misr;
    logic [WIDTH-1:0] w_fb;
    logic [15:0]      w_pat_inc;
    logic [1:0]       w_after_skip;
    logic             w_start_ok;

    // Galois-style shift: the bit leaving the MSB selects the feedback taps,
    // and the whole response word is XORed in on the same cycle.
    assign w_fb      = r_sig[WIDTH-1] ? POLY : '0;
    assign w_misr    = {r_sig[WIDTH-2:0], 1'b0} ^ w_fb ^ bus.RESP;
    assign w_pat_inc = r_pat + 16'd1;

    // A zero-length compaction window goes straight to DONE with SEED held.
    assign w_after_skip = (NP == 16'd0) ? S_DONE : S_RUN;

    // START is only honoured when no run is in flight.
    assign w_start_ok = bus.START && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_pat_nxt   = r_pat;
        w_skip_nxt  = r_skip;
        case (r_state)
            S_IDLE, S_DONE: begin
                // START takes priority over a coincident VALID, which is dropped.
                if (w_start_ok) begin
                    w_sig_nxt   = SEED;
                    w_pat_nxt   = 16'd0;
                    w_skip_nxt  = WU;
                    w_state_nxt = (WU != 8'd0) ? S_SKIP : w_after_skip;
                end
            end
            S_SKIP: begin
                if (bus.VALID) begin
                    w_skip_nxt = r_skip - 8'd1;
                    if (r_skip == 8'd1) begin
                        w_state_nxt = w_after_skip;
                    end
                end
            end
            S_RUN: begin
                if (bus.VALID) begin
                    w_sig_nxt = w_misr;
                    w_pat_nxt = w_pat_inc;
                    if (w_pat_inc == NP) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register rather than being decoded after it.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sig   <= SEED;
            r_pat   <= 16'd0;
            r_skip  <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_pat   <= w_pat_nxt;
            r_skip  <= w_skip_nxt;
            r_busy  <= (w_state_nxt == S_SKIP) || (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.PAT_CNT   = r_pat;
    assign bus.SIGNATURE = r_sig;

`ifdef S713_RESP_MISR_CMP_EN
    logic r_pass;

    // Compares the already-registered DONE/SIGNATURE, so PASS trails DONE by
    // one cycle; a START that is not accepted can only occur while DONE=0,
    // which already forces PASS low.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_pass <= 1'b0;
        end else if (w_start_ok) begin
            r_pass <= 1'b0;
        end else begin
            r_pass <= r_done && (r_sig == bus.EXP_SIG);
        end
    end

    assign bus.PASS = r_pass;
`endif

endmodule

// File: doc/s713_resp_misr.md
Name: s713_resp_misr

Overview:
- Downstream response compactor for the s713 benchmark core.
- Consumes the 23 primary outputs of s713 each cycle and folds them into a multiple-input signature register (MISR).
- A control FSM skips a programmable warm-up window while the core's 19 flip-flops settle, compacts a fixed number of patterns, then holds the final signature for readout.
- Sits between the s713 instance and the BIST/tester readout logic.

Parameters:
- WIDTH, 23, signature and response width; must be 23 when attached to s713; smaller values allowed for unit test.
- POLY, 23'h000021, feedback taps XORed in when the MSB shifts out; bit 0 corresponds to the x^0 term.
- SEED, 0, signature value after reset and at start of each run.
- WARMUP, 4, number of VALID cycles discarded before compaction; range 0..255.
- NUM_PATTERNS, 1024, number of VALID cycles compacted; range 0..65535.

Ports:
- CK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- VALID  in  1  RESP is a valid s713 response this cycle.
- RESP  in  WIDTH  s713 outputs {G107,G83..G85,G86BF..G89BF,G90..G92,G94,G95BF..G101BF,G103BF..G106BF}, MSB first.
- BUSY  out  1  high in SKIP or RUN.
- DONE  out  1  high in DONE state.
- PAT_CNT  out  16  count of patterns compacted in the current run.
- SIGNATURE  out  WIDTH  current MISR contents.

Behaviour:
- Clock and reset: one clock, CK; reset RST is asynchronous and active-high.
- Reset values (asynchronous, immediate): state=IDLE, BUSY=0, DONE=0, PAT_CNT=0, SIGNATURE=SEED, skip counter=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- MISR update, in RUN with VALID=1: sig_next = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ RESP.
- IDLE:
  - START=1 loads SIGNATURE=SEED, PAT_CNT=0, skip counter=WARMUP.
  - Next state is SKIP if WARMUP>0.
  - Otherwise next state is RUN, or DONE if NUM_PATTERNS==0.
- SKIP:
  - Each VALID cycle decrements the skip counter; RESP is ignored.
  - When the counter decrements from 1 to 0, next state is RUN, or DONE if NUM_PATTERNS==0.
  - VALID=0: no change.
- RUN:
  - Each VALID cycle applies the MISR update and increments PAT_CNT.
  - On the cycle where PAT_CNT becomes NUM_PATTERNS, next state is DONE.
  - VALID=0: SIGNATURE and PAT_CNT hold.
- DONE:
  - SIGNATURE and PAT_CNT are frozen and VALID is ignored.
  - START=1 restarts exactly as from IDLE.
- Latency: DONE rises on the clock edge that captures the final pattern, so it is visible the cycle after the final VALID.
- START while BUSY is ignored; a run cannot be restarted mid-run except by RST.
- START and VALID in the same IDLE/DONE cycle: START wins; that VALID is neither skipped nor compacted.
- RST asserted mid-run aborts immediately; the partial signature is lost.
- PAT_CNT never wraps, since NUM_PATTERNS ≤ 65535.

Optional Feature:
- Macro: S713_RESP_MISR_CMP_EN.
- Defined:
  - Adds input EXP_SIG [WIDTH-1:0] and output PASS (1 bit, reset 0).
  - PASS = DONE && (SIGNATURE == EXP_SIG), registered, so valid one cycle after DONE rises.
  - PASS clears on START or RST.
- Undefined: neither port exists; no comparator logic.

Test Plan:
- Common overrides for these cases: WIDTH=4, POLY=4'h3, SEED=0, WARMUP=0, NUM_PATTERNS=5.
- Basic compaction: START, then VALID RESP=1,0,0,0,0 -> SIGNATURE 1,2,4,8,3; DONE=1 and PAT_CNT=5 the cycle after the 5th VALID; BUSY=0.
- Warm-up: WARMUP=2; START, RESP=F,F,1,0,0,0,0 all VALID -> first two discarded, final SIGNATURE=4'h3, PAT_CNT=5.
- VALID gaps and DONE freeze: same data as the basic case with VALID=0 between every pattern -> SIGNATURE/PAT_CNT hold during gaps, final 4'h3; extra VALIDs after DONE leave 4'h3.
- Reset mid-run and START collision: after 3 patterns, pulse START (ignored, PAT_CNT stays 3), then assert RST -> same cycle BUSY=0, SIGNATURE=0, PAT_CNT=0; a re-run gives 4'h3.
- Restart from DONE: START in DONE -> SIGNATURE=SEED, PAT_CNT=0, BUSY=1 next cycle; NUM_PATTERNS=0 build -> DONE right after START with SIGNATURE=SEED.
- Compare feature (S713_RESP_MISR_CMP_EN): EXP_SIG=4'h3 -> PASS=1 one cycle after DONE; EXP_SIG=4'h2 -> PASS stays 0; PASS=0 throughout the run.
